// File: rtl/xor_op_arbiter_pkg.sv
// Shared types and helpers for the ALU-cluster operator arbiters.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package xor_op_arbiter_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = $clog2(MAX_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Round-robin search starting at ptr. Requests are zero-padded to MAX_REQ,
  // so wrapping modulo MAX_REQ visits ptr..NUM_REQ-1 and then 0..ptr-1,
  // which is the same order as wrapping modulo NUM_REQ.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] ptr);
    rr_pick_t             pick;
    logic [MAX_IDX_W-1:0] cand;
    pick = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = ptr + MAX_IDX_W'(k);
      if (!pick.found && req[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/xor_op_if.sv
// XorOp operand/result interface and its native XOR implementation.
// Latency: combinational.
// Backpressure: none; the owner of the interface sequences the operands.
interface XorOp #(
  parameter int W = 8
);
  logic [W-1:0] lhs;
  logic [W-1:0] rhs;
  logic [W-1:0] result;

  modport Injected (input lhs, input rhs, output result);
endinterface

// Plain bitwise XOR at the interface width; no extension or truncation.
// Latency: combinational.
// Backpressure: none.
module XorOpNative (
  XorOp.Injected xop
);
  assign xop.result = xop.lhs ^ xop.rhs;
endmodule

// File: rtl/xor_op_rr_grant.sv
// Combinational round-robin picker: one-hot grant plus index of the winner.
// Latency: combinational.
// Backpressure: en_i low forces an all-zero grant.
module xor_op_rr_grant
  import xor_op_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  input  logic                en_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  rr_pick_t pick;

  // Search from ptr, then gate the one-hot grant with the enable.
  always_comb begin
    pick    = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(ptr_i));
    idx_o   = ID_WIDTH'(pick.idx);
    grant_o = '0;
    if (en_i && pick.found) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/xor_op_arbiter.sv
// Round-robin arbiter sharing one XorOp unit; result tagged with requester id.
// Latency: 1 cycle request-to-resp_valid (2 with XOR_OP_ARBITER_PIPE_EN); 1 op/cycle.
// Backpressure: resp_ready low holds the result and drops all req_ready once full.
module xor_op_arbiter
  import xor_op_arbiter_pkg::*;
#(
  parameter  int OPERAND_WIDTH = 8,
  parameter  int NUM_REQ       = 4,
  localparam int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_lhs,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_rhs,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [OPERAND_WIDTH-1:0]         resp_result,
  output logic [ID_WIDTH-1:0]              resp_id,
  output logic                             busy
);

  arb_state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]        ptr_q, ptr_d;
  logic [OPERAND_WIDTH-1:0]   res_q, res_d;
  logic [ID_WIDTH-1:0]        id_q, id_d;
  logic [NUM_REQ-1:0]         grant;
  logic [ID_WIDTH-1:0]        g_idx;
  logic                       can_accept;
  logic                       out_free;
  logic                       xfer;
  logic [OPERAND_WIDTH-1:0]   sel_lhs;
  logic [OPERAND_WIDTH-1:0]   sel_rhs;

  XorOp #(.W(OPERAND_WIDTH)) u_xop ();
  XorOpNative u_xor_native (.xop(u_xop));

  xor_op_rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_grant (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (can_accept),
    .grant_o (grant),
    .idx_o   (g_idx)
  );

  // Output register can take new data when empty or being drained this cycle.
  assign out_free  = (state_q == EMPTY) | resp_ready;
  assign xfer      = |grant;
  assign req_ready = grant;
  assign sel_lhs   = req_lhs[g_idx*OPERAND_WIDTH +: OPERAND_WIDTH];
  assign sel_rhs   = req_rhs[g_idx*OPERAND_WIDTH +: OPERAND_WIDTH];

  assign resp_valid  = (state_q == FULL);
  assign resp_result = res_q;
  assign resp_id     = id_q;

`ifdef XOR_OP_ARBITER_PIPE_EN
  logic                     s1_vld_q, s1_vld_d;
  logic [OPERAND_WIDTH-1:0] s1_lhs_q, s1_lhs_d;
  logic [OPERAND_WIDTH-1:0] s1_rhs_q, s1_rhs_d;
  logic [ID_WIDTH-1:0]      s1_id_q, s1_id_d;

  // Stage 1 accepts when it is empty or moving into the output register.
  assign can_accept = !s1_vld_q | out_free;
  assign u_xop.lhs  = s1_lhs_q;
  assign u_xop.rhs  = s1_rhs_q;
  assign busy       = s1_vld_q | resp_valid;

  // Operand stage next state: load on grant, empty when drained with no grant.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_lhs_d = s1_lhs_q;
    s1_rhs_d = s1_rhs_q;
    s1_id_d  = s1_id_q;
    if (can_accept) begin
      s1_vld_d = xfer;
    end
    if (xfer) begin
      s1_lhs_d = sel_lhs;
      s1_rhs_d = sel_rhs;
      s1_id_d  = g_idx;
    end
  end

  // Operand stage registers; reset drops any operand in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_lhs_q <= '0;
      s1_rhs_q <= '0;
      s1_id_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_lhs_q <= s1_lhs_d;
      s1_rhs_q <= s1_rhs_d;
      s1_id_q  <= s1_id_d;
    end
  end

  // Output FSM: refill from stage 1 whenever the output register is free.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    id_d    = id_q;
    if (out_free) begin
      state_d = s1_vld_q ? FULL : EMPTY;
      if (s1_vld_q) begin
        res_d = u_xop.result;
        id_d  = s1_id_q;
      end
    end
  end
`else
  assign can_accept = out_free;
  assign u_xop.lhs  = sel_lhs;
  assign u_xop.rhs  = sel_rhs;
  assign busy       = resp_valid;

  // Output FSM: capture the granted result directly; back-to-back without bubble.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    id_d    = id_q;
    if (out_free) begin
      state_d = xfer ? FULL : EMPTY;
      if (xfer) begin
        res_d = u_xop.result;
        id_d  = g_idx;
      end
    end
  end
`endif

  // Pointer moves past the winner only when a request is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (g_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  // State register; asynchronous reset discards the held result without handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result, id and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      id_q  <= '0;
      ptr_q <= '0;
    end else begin
      res_q <= res_d;
      id_q  <= id_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_xor_op_arbiter.sv
// Self-checking bench for xor_op_arbiter: directed literal cases plus random traffic.
// Reference: queue-of-results model with round-robin order computed by modulo search.
// Drives inputs 1 time unit after the rising edge; compares on the falling edge.
module tb_xor_op_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef XOR_OP_ARBITER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_lhs;
  logic [N*W-1:0] req_rhs;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_result;
  logic [IW-1:0] resp_id;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  xor_op_arbiter #(.OPERAND_WIDTH(W), .NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_lhs     (req_lhs),
    .req_rhs     (req_rhs),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted request becomes one entry {lhs^rhs, id}. An entry is visible
  // on the response port once it has reached the output slot; in pipelined
  // builds it first spends at least one cycle in the operand slot.
  typedef struct {
    logic [W-1:0] res;
    int           id;
    bit           vis;
  } ent_t;

  ent_t mq[$];
  int   m_ptr;
  int   m_g;
  logic [N-1:0] m_rdy;
  ent_t m_e;

  function automatic bit m_has_vis();
    return (mq.size() > 0) && mq[0].vis;
  endfunction

  function automatic bit m_has_s1();
    foreach (mq[i]) if (!mq[i].vis) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_accept();
    if (PIPE) return !m_has_s1() || !m_has_vis() || resp_ready;
    return !m_has_vis() || resp_ready;
  endfunction

  function automatic int m_grant();
    if (!m_accept()) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Compare every cycle, then advance the model to what the next rising edge does.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      m_ptr = 0;
    end else begin
      m_g   = m_grant();
      m_rdy = (m_g < 0) ? '0 : N'(1) << m_g;
      chk("req_ready", req_ready, m_rdy);
      chk("resp_valid", resp_valid, m_has_vis());
      chk("busy", busy, mq.size() > 0);
      if (m_has_vis()) begin
        chk("resp_result", resp_result, mq[0].res);
        chk("resp_id", resp_id, mq[0].id);
      end
      if (m_has_vis() && resp_ready) void'(mq.pop_front());
      if (!m_has_vis()) begin
        foreach (mq[i]) if (!mq[i].vis) begin mq[i].vis = 1'b1; break; end
      end
      if (m_g >= 0) begin
        m_e.res = req_lhs[m_g*W +: W] ^ req_rhs[m_g*W +: W];
        m_e.id  = m_g;
        m_e.vis = !PIPE;
        mq.push_back(m_e);
        m_ptr = (m_g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] granted;
  int           ord [5];
  int           dens;

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    // results per requester: 0:FE 1:F0 2:CC 3:AA
    req_lhs    = {8'hA4, 8'hF0, 8'hFF, 8'h01};
    req_rhs    = {8'h0E, 8'h3C, 8'h0F, 8'hFF};
    repeat (3) tick();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

`ifndef XOR_OP_ARBITER_PIPE_EN
    // single request, requester 2
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1 chk("single_rdy", req_ready, 4'b0100);
    tick();
    chk("single_valid", resp_valid, 1);
    chk("single_result", resp_result, 8'hCC);
    chk("single_id", resp_id, 2);
    // all requesting, pointer now at 3
    req_valid = 4'b1111;
    ord = '{3, 0, 1, 2, 3};
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_rdy", req_ready, 32'(1) << ord[k]);
      tick();
      chk("rr_valid", resp_valid, 1);
      chk("rr_id", resp_id, ord[k]);
    end
    // backpressure, full with requester 3 result
    resp_ready = 1'b0; req_valid = 4'b0011;
    repeat (5) begin
      #1 chk("bp_rdy", req_ready, 0);
      chk("bp_id", resp_id, 3);
      chk("bp_result", resp_result, 8'hAA);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_rdy", req_ready, 4'b0001);
    tick();
    chk("bp_release_result", resp_result, 8'hFE);
    #1 chk("bp_next_rdy", req_ready, 4'b0010);
    tick();
    chk("bp_next_result", resp_result, 8'hF0);
    // wrap: bring pointer to 3, then 3 -> 0 -> 1
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1001;
    #1 chk("wrap_rdy3", req_ready, 4'b1000);
    tick();
    #1 chk("wrap_rdy0", req_ready, 4'b0001);
    tick();
    chk("wrap_id0", resp_id, 0);
    req_valid = 4'b1111;
    #1 chk("wrap_ptr1", req_ready, 4'b0010);
    // reset mid-operation while holding AA
    req_valid = 4'b1000;
    tick();
    req_valid = '0; resp_ready = 1'b0;
    tick();
    chk("pre_rst_result", resp_result, 8'hAA);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_result", resp_result, 0);
    chk("midrst_busy", busy, 0);
    tick();
    rst = 1'b1; req_valid = 4'b1111; resp_ready = 1'b1;
    #1 chk("post_rst_ptr0", req_ready, 4'b0001);
    tick();
`else
    // single request through the operand stage
    req_valid = 4'b0010; resp_ready = 1'b1;
    #1 chk("pipe_rdy", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("pipe_lat1_valid", resp_valid, 0);
    chk("pipe_lat1_busy", busy, 1);
    tick();
    chk("pipe_valid", resp_valid, 1);
    chk("pipe_result", resp_result, 8'hF0);
    chk("pipe_id", resp_id, 1);
    // stall with both stages occupied
    resp_ready = 1'b0; req_valid = 4'b0100;
    #1 chk("pipe_s1_rdy", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    repeat (3) begin
      req_valid = 4'b0001;
      #1 chk("pipe_stall_rdy", req_ready, 0);
      chk("pipe_stall_result", resp_result, 8'hF0);
      chk("pipe_stall_busy", busy, 1);
      tick();
    end
    req_valid = '0; resp_ready = 1'b1;
    tick();
    chk("pipe_drain_result", resp_result, 8'hCC);
    chk("pipe_drain_id", resp_id, 2);
    tick();
    chk("pipe_empty_valid", resp_valid, 0);
    chk("pipe_empty_busy", busy, 0);
`endif

    // randomized traffic; requesters hold valid/operands until granted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      granted = req_valid & req_ready;
      @(posedge clk);
      #1;
      dens = (cyc / 400) % 4;
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !granted[i])) begin
          req_valid[i]     = ($urandom_range(0, 3) < dens);
          req_lhs[i*W +: W] = W'($urandom);
          req_rhs[i*W +: W] = W'($urandom);
        end
      end
      if ((cyc / 250) % 3 == 0) resp_ready = 1'b1;
      else                      resp_ready = ($urandom_range(0, 3) != 0);
    end

    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
